// File: rtl/h_sync_gen.sv
// Horizontal VGA timing generator: counts pixel slots per line, decodes the
// visible/front/sync/back regions and drives registered hsync, h_active and line_end.
module h_sync_gen #(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_FRONT   = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BACK    = 160,
  parameter logic        HSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             hsync,
  output logic             h_active,
  output logic [CNT_W-1:0] pixel_x,
  output logic             line_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  // Last slot of each region; the enabled edge leaving this slot changes state.
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] FRONT_LAST  = CNT_W'(H_VISIBLE + H_FRONT - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'(H_TOTAL - 1);

  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_param_check
    $fatal(1, "h_sync_gen: invalid horizontal timing parameters");
  end

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } state_t;

  state_t state;

  // Outputs are updated together with the state transition, so they always
  // match the registered state/pixel_x without a decode stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACTIVE;
      pixel_x  <= '0;
      h_active <= 1'b1;
      hsync    <= ~HSYNC_POL;
      line_end <= 1'b0;
    end else begin
      line_end <= 1'b0;
      if (en) begin
        pixel_x <= pixel_x + CNT_W'(1);
        case (state)
          ACTIVE: begin
            if (pixel_x == ACTIVE_LAST) begin
              state    <= FRONT;
              h_active <= 1'b0;
            end
          end
          FRONT: begin
            if (pixel_x == FRONT_LAST) begin
              state <= SYNC;
              hsync <= HSYNC_POL;
            end
          end
          SYNC: begin
            if (pixel_x == SYNC_LAST) begin
              state <= BACK;
              hsync <= ~HSYNC_POL;
            end
          end
          BACK: begin
            if (pixel_x == BACK_LAST) begin
              state    <= ACTIVE;
              pixel_x  <= '0;
              h_active <= 1'b1;
              line_end <= 1'b1;
            end
          end
          default: begin
            state    <= ACTIVE;
            pixel_x  <= '0;
            h_active <= 1'b1;
            hsync    <= ~HSYNC_POL;
          end
        endcase
      end
    end
  end

endmodule
